// File: rtl/dec_trigger_chain.sv
// Decode-stage PC trigger unit.
// Each trigger compares every decode lane's PC (exact or NAPOT-masked), counts
// hits against a per-trigger limit, and even/odd trigger pairs can be chained
// so that the odd trigger only reports after the even trigger has armed the pair.
module dec_trigger_chain #(
  parameter int NUM_TRIG  = 4,
  parameter int NUM_LANES = 2,
  parameter int CNT_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_TRIG-1:0]           cfg_wr,
  input  logic [NUM_TRIG-1:0]           trig_execute,
  input  logic [NUM_TRIG-1:0]           trig_select,
  input  logic [NUM_TRIG-1:0]           trig_match,
  input  logic [NUM_TRIG-1:0]           trig_chain,
  input  logic [NUM_TRIG*32-1:0]        trig_tdata2,
  input  logic [NUM_TRIG*CNT_W-1:0]     trig_count,
  input  logic [NUM_LANES-1:0]          lane_valid,
  input  logic [NUM_LANES*31-1:0]       lane_pc,
  output logic [NUM_LANES*NUM_TRIG-1:0] trig_match_d,
  output logic [NUM_TRIG*CNT_W-1:0]     trig_hit_cnt,
  output logic [NUM_TRIG-1:0]           trig_armed
);

  localparam int NUM_PAIR = NUM_TRIG / 2;

  logic [NUM_TRIG-1:0][CNT_W-1:0]     r_cnt;
  logic [NUM_PAIR-1:0]                r_arm;

  logic [NUM_TRIG-1:0][CNT_W-1:0]     w_cnt_next;
  logic [NUM_PAIR-1:0]                w_arm_next;
  logic [NUM_TRIG-1:0][NUM_LANES-1:0] w_hit;
  logic [NUM_TRIG-1:0][NUM_LANES-1:0] w_fire;
  logic [NUM_TRIG-1:0][NUM_LANES-1:0] w_out;
  logic [NUM_TRIG-1:0]                w_pair_lo;
  logic [NUM_TRIG-1:0]                w_pair_hi;
  logic [NUM_PAIR-1:0]                w_unused_chain_odd;
  logic                               w_active;
  logic [CNT_W-1:0]                   w_cnt_run;
  logic [CNT_W-1:0]                   w_lim;
  logic                               w_arm_run;

  // Reset and flush both discard the current cycle's hits.
  assign w_active = ~rst & ~flush;

  genvar gi, gl;
  generate
    for (gi = 0; gi < NUM_TRIG; gi++) begin : g_trig
      logic [31:0] w_tdata2;
      logic [31:0] w_dc;
      assign w_tdata2 = trig_tdata2[gi*32 +: 32];
      // x ^ (x+1) sets bits [k:0] where k is the count of trailing ones;
      // an all-ones tdata2 wraps to zero and yields a full don't-care mask.
      assign w_dc = trig_match[gi] ? (w_tdata2 ^ (w_tdata2 + 32'd1)) : 32'd0;
      assign trig_hit_cnt[gi*CNT_W +: CNT_W] = r_cnt[gi];

      for (gl = 0; gl < NUM_LANES; gl++) begin : g_lane
        logic [31:0] w_addr;
        // Bit 0 is borrowed from tdata2 so it never causes a mismatch.
        assign w_addr = {lane_pc[gl*31 +: 31], w_tdata2[0]};
        // A CSR write suppresses this trigger's hits in the same cycle.
        assign w_hit[gi][gl] = lane_valid[gl] & trig_execute[gi] & ~trig_select[gi] &
                               ~cfg_wr[gi] & w_active &
                               (((w_addr ^ w_tdata2) & ~w_dc) == 32'd0);
        assign trig_match_d[gl*NUM_TRIG + gi] = w_out[gi][gl];
      end
    end

    for (gi = 0; gi < NUM_PAIR; gi++) begin : g_pair
      assign w_pair_lo[2*gi]     = trig_chain[2*gi];
      assign w_pair_lo[2*gi+1]   = 1'b0;
      assign w_pair_hi[2*gi]     = 1'b0;
      assign w_pair_hi[2*gi+1]   = trig_chain[2*gi];
      assign trig_armed[2*gi]    = r_arm[gi];
      assign trig_armed[2*gi+1]  = 1'b0;
      // Odd chain bits carry no meaning for this unit.
      assign w_unused_chain_odd[gi] = trig_chain[2*gi+1];
    end
  endgenerate

  // Per-trigger hit counting (oldest lane first), then chain arming and fire routing.
  always_comb begin
    w_fire     = '0;
    w_out      = '0;
    w_cnt_next = r_cnt;
    w_arm_next = '0;
    w_cnt_run  = '0;
    w_lim      = '0;
    w_arm_run  = 1'b0;

    for (int t = 0; t < NUM_TRIG; t++) begin
      w_lim = trig_count[t*CNT_W +: CNT_W];
      if (w_lim == '0) w_lim = CNT_W'(1);
      w_cnt_run = r_cnt[t];
      for (int l = 0; l < NUM_LANES; l++) begin
        if (w_hit[t][l]) begin
          if ((w_cnt_run + CNT_W'(1)) >= w_lim) begin
            w_fire[t][l] = 1'b1;
            w_cnt_run    = '0;
          end else begin
            w_cnt_run = w_cnt_run + CNT_W'(1);
          end
        end
      end
      w_cnt_next[t] = cfg_wr[t] ? '0 : w_cnt_run;
      if (!w_pair_lo[t] && !w_pair_hi[t]) w_out[t] = w_fire[t];
    end

    for (int p = 0; p < NUM_PAIR; p++) begin
      w_arm_run = r_arm[p];
      if (w_pair_lo[2*p]) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          // Odd trigger consumes the arm first, so a same-lane even fire
          // only arms for younger lanes and later cycles.
          if (w_fire[2*p+1][l] && w_arm_run) begin
            w_out[2*p+1][l] = 1'b1;
            w_arm_run       = 1'b0;
          end
          if (w_fire[2*p][l]) w_arm_run = 1'b1;
        end
      end
      w_arm_next[p] = w_arm_run & w_pair_lo[2*p] & ~flush & ~cfg_wr[2*p] & ~cfg_wr[2*p+1];
    end
  end

  // Counter and arm state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_arm <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      r_arm <= w_arm_next;
    end
  end

endmodule

// File: tb/tb_dec_trigger_chain.sv
// Directed bench for dec_trigger_chain: exact/NAPOT match, hit counting,
// chaining, flush, CSR write and reset behaviour with hand-computed values.
module tb_dec_trigger_chain;

  localparam int NUM_TRIG  = 4;
  localparam int NUM_LANES = 2;
  localparam int CNT_W     = 8;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          flush;
  logic [NUM_TRIG-1:0]           cfg_wr;
  logic [NUM_TRIG-1:0]           trig_execute;
  logic [NUM_TRIG-1:0]           trig_select;
  logic [NUM_TRIG-1:0]           trig_match;
  logic [NUM_TRIG-1:0]           trig_chain;
  logic [NUM_TRIG*32-1:0]        trig_tdata2;
  logic [NUM_TRIG*CNT_W-1:0]     trig_count;
  logic [NUM_LANES-1:0]          lane_valid;
  logic [NUM_LANES*31-1:0]       lane_pc;
  logic [NUM_LANES*NUM_TRIG-1:0] trig_match_d;
  logic [NUM_TRIG*CNT_W-1:0]     trig_hit_cnt;
  logic [NUM_TRIG-1:0]           trig_armed;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] NAPOT_PC  [4] = '{32'h0000_1000, 32'h0000_11FE, 32'h0000_1200, 32'h0000_0FFE};
  localparam logic [31:0] NAPOT_EXP [4] = '{32'h01, 32'h01, 32'h00, 32'h00};

  always #5 clk = ~clk;

  dec_trigger_chain #(
    .NUM_TRIG (NUM_TRIG),
    .NUM_LANES(NUM_LANES),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .cfg_wr      (cfg_wr),
    .trig_execute(trig_execute),
    .trig_select (trig_select),
    .trig_match  (trig_match),
    .trig_chain  (trig_chain),
    .trig_tdata2 (trig_tdata2),
    .trig_count  (trig_count),
    .lane_valid  (lane_valid),
    .lane_pc     (lane_pc),
    .trig_match_d(trig_match_d),
    .trig_hit_cnt(trig_hit_cnt),
    .trig_armed  (trig_armed)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    lane_valid = v;
    lane_pc    = {pc1[31:1], pc0[31:1]};
  endtask

  task automatic cfg(input int i, input logic [31:0] td, input logic m,
                     input logic [7:0] cnt, input logic ex);
    trig_tdata2[i*32 +: 32]      = td;
    trig_match[i]                = m;
    trig_count[i*CNT_W +: CNT_W] = cnt;
    trig_execute[i]              = ex;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; cfg_wr = '0; trig_execute = '0; trig_select = '0;
    trig_match = '0; trig_chain = '0; trig_tdata2 = '0; trig_count = '0;
    lane_valid = '0; lane_pc = '0;

    // Reset: a matching lane must not fire while rst is high.
    cfg(0, 32'h0000_1000, 1'b0, 8'd1, 1'b1);
    set_lanes(2'b01, 32'h1000, 32'h0);
    @(negedge clk);
    check_value("rst_match_d", 32'(trig_match_d), 32'h0);
    cyc(); cyc();
    check_value("rst_hit_cnt", trig_hit_cnt, 32'h0);
    check_value("rst_armed", 32'(trig_armed), 32'h0);
    rst = 1'b0;

    // Exact match.
    @(negedge clk);
    check_value("exact_hit", 32'(trig_match_d), 32'h01);
    cyc();
    set_lanes(2'b01, 32'h1002, 32'h0);
    @(negedge clk);
    check_value("exact_miss", 32'(trig_match_d), 32'h00);
    cyc();
    set_lanes(2'b10, 32'h0, 32'h1000);
    @(negedge clk);
    check_value("exact_lane1", 32'(trig_match_d), 32'h10);
    cyc();

    // NAPOT match over 0x1000..0x11FF.
    cfg(0, 32'h0000_10FF, 1'b1, 8'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      set_lanes(2'b01, NAPOT_PC[i], 32'h0);
      @(negedge clk);
      check_value($sformatf("napot_%0d", i), 32'(trig_match_d), NAPOT_EXP[i]);
      cyc();
    end
    set_lanes(2'b11, 32'h1200, 32'h1100);
    @(negedge clk);
    check_value("napot_lane1", 32'(trig_match_d), 32'h10);
    cyc();

    // Hit counting with limit 3.
    cfg(0, 32'h0000_1000, 1'b0, 8'd3, 1'b1);
    set_lanes(2'b00, 32'h0, 32'h0);
    cfg_wr = 4'b0001;
    cyc();
    cfg_wr = 4'b0000;
    check_value("cnt_clear", trig_hit_cnt, 32'h0);
    set_lanes(2'b11, 32'h1000, 32'h1000);
    @(negedge clk);
    check_value("cnt_c0_match", 32'(trig_match_d), 32'h00);
    cyc();
    check_value("cnt_c0_cnt", trig_hit_cnt, 32'h0000_0002);
    @(negedge clk);
    check_value("cnt_c1_match", 32'(trig_match_d), 32'h01);
    cyc();
    check_value("cnt_c1_cnt", trig_hit_cnt, 32'h0000_0001);

    // Chain T0 -> T1.
    set_lanes(2'b00, 32'h0, 32'h0);
    cfg(0, 32'h0000_0100, 1'b0, 8'd1, 1'b1);
    cfg(1, 32'h0000_0200, 1'b0, 8'd1, 1'b1);
    trig_chain = 4'b0001;
    cfg_wr = 4'b0011;
    cyc();
    cfg_wr = 4'b0000;
    check_value("chain_clear", trig_hit_cnt, 32'h0);
    set_lanes(2'b01, 32'h200, 32'h0);
    @(negedge clk);
    check_value("chain_a_match", 32'(trig_match_d), 32'h00);
    cyc();
    check_value("chain_a_armed", 32'(trig_armed), 32'h0);
    set_lanes(2'b11, 32'h100, 32'h200);
    @(negedge clk);
    check_value("chain_b_match", 32'(trig_match_d), 32'h20);
    cyc();
    check_value("chain_b_armed", 32'(trig_armed), 32'h0);
    set_lanes(2'b01, 32'h100, 32'h0);
    @(negedge clk);
    check_value("chain_arm_match", 32'(trig_match_d), 32'h00);
    cyc();
    check_value("chain_arm_armed", 32'(trig_armed), 32'h1);
    set_lanes(2'b01, 32'h200, 32'h0);
    @(negedge clk);
    check_value("chain_armed_fire", 32'(trig_match_d), 32'h02);
    cyc();
    check_value("chain_disarm", 32'(trig_armed), 32'h0);

    // Flush clears arm; following T1 hit stays silent.
    set_lanes(2'b01, 32'h100, 32'h0);
    cyc();
    check_value("flush_pre_armed", 32'(trig_armed), 32'h1);
    set_lanes(2'b00, 32'h0, 32'h0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check_value("flush_armed", 32'(trig_armed), 32'h0);
    set_lanes(2'b01, 32'h200, 32'h0);
    @(negedge clk);
    check_value("flush_t1_match", 32'(trig_match_d), 32'h00);
    cyc();

    // CSR write on T2 clears its counter and masks its hit.
    cfg(2, 32'h0000_3000, 1'b0, 8'd2, 1'b1);
    set_lanes(2'b00, 32'h0, 32'h0);
    cfg_wr = 4'b0100;
    cyc();
    cfg_wr = 4'b0000;
    set_lanes(2'b01, 32'h3000, 32'h0);
    @(negedge clk);
    check_value("cfg_t2_match", 32'(trig_match_d), 32'h00);
    cyc();
    check_value("cfg_t2_cnt1", trig_hit_cnt, 32'h0001_0000);
    cfg_wr = 4'b0100;
    @(negedge clk);
    check_value("cfg_wr_match", 32'(trig_match_d), 32'h00);
    cyc();
    cfg_wr = 4'b0000;
    check_value("cfg_wr_cnt", trig_hit_cnt, 32'h0);

    // Reset mid-operation with a nonzero counter and the pair armed.
    set_lanes(2'b11, 32'h3000, 32'h100);
    @(negedge clk);
    check_value("mid_pre_match", 32'(trig_match_d), 32'h00);
    cyc();
    check_value("mid_pre_cnt", trig_hit_cnt, 32'h0001_0000);
    check_value("mid_pre_armed", 32'(trig_armed), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check_value("mid_rst_match", 32'(trig_match_d), 32'h00);
    cyc();
    check_value("mid_rst_cnt", trig_hit_cnt, 32'h0);
    check_value("mid_rst_armed", 32'(trig_armed), 32'h0);
    rst = 1'b0;
    set_lanes(2'b00, 32'h0, 32'h0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
